// File: rtl/sparse_cnn_pkg.sv
// Shared types and helpers for the sparse convolution PE sequencer.
// Default widths, lane count, FSM state encodings and the group ceil-divide.
package sparse_cnn_pkg;

  localparam int DW_DEF  = 16;
  localparam int LANES   = 4;
  localparam int MAX_OUT = 4;
  localparam int GW      = DW_DEF + 1;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t S_IDLE  = 2'd0;
  localparam sched_state_t S_RUN   = 2'd1;
  localparam sched_state_t S_DRAIN = 2'd2;
  localparam sched_state_t S_DONE  = 2'd3;

  // One extra bit so F = 2^16-1 cannot overflow the rounding add.
  function automatic logic [GW-1:0] ceil_div(
    input logic [GW-1:0] n,
    input logic [GW-1:0] d
  );
    return (n + d - GW'(1)) / d;
  endfunction

endpackage

// File: rtl/sched_outstanding_ctr.sv
// Saturating up/down counter of issued-but-unretired PE operations.
// Exposes the next-cycle full/empty state so issue_valid can stay registered.
module sched_outstanding_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full_nxt,
  output logic empty_nxt
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && cnt_q != CW'(MAX))
      cnt_d = cnt_q + CW'(1);
    else if (dec && !inc && cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
    full_nxt  = (cnt_d == CW'(MAX));
    empty_nxt = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sparse_conv_sched.sv
// Sparse convolution PE sequencer: walks (weight, feature group) pairs.
// Optional stall_cycles counter enabled by defining SCHED_PERF_CNT_EN.
module sparse_conv_sched
  import sparse_cnn_pkg::*;
#(
  parameter int doublewordLength = DW_DEF,
  parameter int lanes            = LANES,
  parameter int maxOutstanding   = MAX_OUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [doublewordLength-1:0] feacture_valid_num,
  input  logic [doublewordLength-1:0] weight_valid_num,
  output logic                        busy,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [doublewordLength-1:0] curr_pixel,
  output logic [doublewordLength-1:0] curr_weight,
  output logic [lanes-1:0]            lane_mask,
  input  logic                        pe_retire,
  output logic                        out_valid
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);

  localparam int DW = doublewordLength;
  localparam int XW = DW + 9;

  sched_state_t state_q;
  sched_state_t state_n;

  logic [DW-1:0] f_q;
  logic [DW-1:0] w_q;
  logic [DW:0]   g_q;
  logic [DW:0]   g_calc;
  logic [DW-1:0] pix_n;
  logic [DW-1:0] wt_n;
  logic          hs;
  logic          load;
  logic          last_pix;
  logic          last_wt;
  logic          full_nxt;
  logic          empty_nxt;

  function automatic logic [lanes-1:0] mask_for(
    input logic [DW-1:0] p,
    input logic [DW-1:0] f
  );
    logic [XW-1:0]    base;
    logic [lanes-1:0] m;
    base = XW'(p) * XW'(lanes);
    for (int i = 0; i < lanes; i++)
      m[i] = (base + XW'(i)) < XW'(f);
    return m;
  endfunction

  sched_outstanding_ctr #(
    .MAX(maxOutstanding)
  ) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (hs),
    .dec      (pe_retire),
    .full_nxt (full_nxt),
    .empty_nxt(empty_nxt)
  );

  always_comb begin
    hs       = issue_valid && issue_ready;
    load     = (state_q == S_IDLE) && in_valid;
    g_calc   = (DW+1)'(ceil_div(GW'(feacture_valid_num),
                                GW'(lanes)));
    last_pix = ({1'b0, curr_pixel} == g_q - (DW+1)'(1));
    last_wt  = (curr_weight == w_q - DW'(1));
    pix_n    = last_pix ? '0 : curr_pixel + DW'(1);
    wt_n     = last_pix ? curr_weight + DW'(1) : curr_weight;
    state_n  = state_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (in_valid)
          state_n = (feacture_valid_num == '0 ||
                     weight_valid_num == '0) ? S_DONE : S_RUN;
      end
      state_q == S_RUN: begin
        if (hs && last_pix && last_wt)
          state_n = S_DRAIN;
      end
      state_q == S_DRAIN: begin
        if (empty_nxt)
          state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy        <= 1'b0;
      issue_valid <= 1'b0;
      out_valid   <= 1'b0;
      curr_pixel  <= '0;
      curr_weight <= '0;
      lane_mask   <= '0;
      f_q         <= '0;
      w_q         <= '0;
      g_q         <= '0;
    end else begin
      state_q     <= state_n;
      busy        <= (state_n != S_IDLE);
      issue_valid <= (state_n == S_RUN) && !full_nxt;
      out_valid   <= (state_q == S_DONE);
      if (load) begin
        f_q         <= feacture_valid_num;
        w_q         <= weight_valid_num;
        g_q         <= g_calc;
        curr_pixel  <= '0;
        curr_weight <= '0;
        lane_mask   <= mask_for('0, feacture_valid_num);
      end else if (hs) begin
        curr_pixel  <= pix_n;
        curr_weight <= wt_n;
        lane_mask   <= mask_for(pix_n, f_q);
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // Any RUN cycle without a handshake is a stall (PE back-pressure or limit).
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (load)
      stall_cycles <= '0;
    else if (state_q == S_RUN && !hs)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sparse_conv_sched.sv
// Directed self-checking bench for sparse_conv_sched.
// Define SCHED_PERF_CNT_EN to also check stall_cycles.
module tb_sparse_conv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] fv;
  logic [15:0] wv;
  logic        busy;
  logic        issue_valid;
  logic        issue_ready;
  logic [15:0] curr_pixel;
  logic [15:0] curr_weight;
  logic [3:0]  lane_mask;
  logic        pe_retire;
  logic        out_valid;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sparse_conv_sched dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .feacture_valid_num(fv),
    .weight_valid_num  (wv),
    .busy              (busy),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .curr_pixel        (curr_pixel),
    .curr_weight       (curr_weight),
    .lane_mask         (lane_mask),
    .pe_retire         (pe_retire),
    .out_valid         (out_valid)
`ifdef SCHED_PERF_CNT_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  task automatic start_job(input logic [15:0] f, input logic [15:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    fv = f;
    wv = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    issue_ready = 1'b0;
    pe_retire = 1'b0;
    fv = '0;
    wv = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%0b exp=0", busy);
    end
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_issue_valid got=%0b exp=0", issue_valid);
    end
    checks++;
    if (curr_pixel !== 16'd0 || curr_weight !== 16'd0) begin
      failures++;
      $display("FAIL reset_idx got=%0d,%0d exp=0,0",
               curr_pixel, curr_weight);
    end
    checks++;
    if (lane_mask !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mask got=%b exp=0000", lane_mask);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
    end
`ifdef SCHED_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
`endif
    rst = 1'b0;
  endtask

  // Full job, PE always ready, each op retired the cycle after its issue.
  task automatic test_sweep(input logic [15:0] f, input logic [15:0] w,
                            input int exp_iss);
    logic [15:0] ep;
    logic [15:0] ew;
    logic [3:0]  em;
    int g;
    int rem;
    int n_iss;
    int n_out;
    logic hs_prev;
    g = (int'(f) + 3) / 4;
    rem = int'(f) % 4;
    ep = '0;
    ew = '0;
    n_iss = 0;
    n_out = 0;
    hs_prev = 1'b0;
    issue_ready = 1'b1;
    pe_retire = 1'b0;
    start_job(f, w);
    checks++;
    if (busy !== 1'b1 || issue_valid !== 1'b1) begin
      failures++;
      $display("FAIL sweep_first got=busy%0b,valid%0b exp=1,1",
               busy, issue_valid);
    end
    for (int c = 0; c < 50; c++) begin
      if (out_valid === 1'b1) n_out++;
      pe_retire = hs_prev;
      if (issue_valid === 1'b1) begin
        em = (int'(ep) == g - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hf;
        checks++;
        if (curr_pixel !== ep || curr_weight !== ew || lane_mask !== em) begin
          failures++;
          $display("FAIL sweep_issue f=%0d got=(%0d,%0d,%b) exp=(%0d,%0d,%b)",
                   f, curr_pixel, curr_weight, lane_mask, ep, ew, em);
        end
        n_iss++;
        if (int'(ep) == g - 1) begin
          ep = '0;
          ew = ew + 16'd1;
        end else begin
          ep = ep + 16'd1;
        end
      end
      hs_prev = issue_valid && issue_ready;
      @(negedge clk);
    end
    pe_retire = 1'b0;
    checks++;
    if (n_iss != exp_iss) begin
      failures++;
      $display("FAIL sweep_count f=%0d got=%0d exp=%0d", f, n_iss, exp_iss);
    end
    checks++;
    if (n_out != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_done f=%0d got=out%0d,busy%0b exp=1,0",
               f, n_out, busy);
    end
  endtask

  task automatic test_zero();
    issue_ready = 1'b1;
    start_job(16'd0, 16'd5);
    checks++;
    if (busy !== 1'b1 || issue_valid !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_c1 got=%0b%0b%0b exp=100",
               busy, issue_valid, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_c2 got=out%0b,busy%0b,valid%0b exp=1,0,0",
               out_valid, busy, issue_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_drain();
    int n_iss;
    n_iss = 0;
    issue_ready = 1'b1;
    pe_retire = 1'b0;
    start_job(16'd16, 16'd1);
    for (int c = 0; c < 4; c++) begin
      if (issue_valid === 1'b1) n_iss++;
      @(negedge clk);
    end
    checks++;
    if (n_iss != 4 || issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_issue got=%0d,valid%0b exp=4,0",
               n_iss, issue_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL drain_wait got=out%0b,busy%0b exp=0,1",
               out_valid, busy);
    end
    pe_retire = 1'b1;
    repeat (4) @(negedge clk);
    pe_retire = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_early got=%0b exp=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_done got=out%0b,busy%0b exp=1,0",
               out_valid, busy);
    end
    @(negedge clk);
  endtask

  // Handshake and retire land together right at the limit edge.
  task automatic test_overlap();
    int n_iss;
    int n_out;
    n_iss = 0;
    n_out = 0;
    issue_ready = 1'b1;
    pe_retire = 1'b0;
    start_job(16'd32, 16'd1);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (issue_valid !== 1'b1 || curr_pixel !== 16'(c)) begin
        failures++;
        $display("FAIL ovl_fill got=valid%0b,p%0d exp=1,%0d",
                 issue_valid, curr_pixel, c);
      end
      n_iss++;
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || curr_pixel !== 16'd4) begin
      failures++;
      $display("FAIL ovl_limit got=valid%0b,p%0d exp=0,4",
               issue_valid, curr_pixel);
    end
    pe_retire = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b1 || curr_pixel !== 16'd4) begin
      failures++;
      $display("FAIL ovl_resume got=valid%0b,p%0d exp=1,4",
               issue_valid, curr_pixel);
    end
    n_iss++;
    @(negedge clk);
    pe_retire = 1'b0;
    checks++;
    if (issue_valid !== 1'b1 || curr_pixel !== 16'd5) begin
      failures++;
      $display("FAIL ovl_same got=valid%0b,p%0d exp=1,5",
               issue_valid, curr_pixel);
    end
    n_iss++;
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || curr_pixel !== 16'd6) begin
      failures++;
      $display("FAIL ovl_full got=valid%0b,p%0d exp=0,6",
               issue_valid, curr_pixel);
    end
    pe_retire = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (out_valid === 1'b1) n_out++;
      if (issue_valid === 1'b1) n_iss++;
      @(negedge clk);
    end
    pe_retire = 1'b0;
    checks++;
    if (n_iss != 8 || n_out != 1) begin
      failures++;
      $display("FAIL ovl_total got=iss%0d,out%0d exp=8,1", n_iss, n_out);
    end
  endtask

  task automatic test_stall();
    logic [15:0] ep;
    logic [15:0] ew;
    int n_iss;
    int n_out;
    int stall_left;
    logic hs_prev;
    ep = '0;
    ew = '0;
    n_iss = 0;
    n_out = 0;
    stall_left = 5;
    hs_prev = 1'b0;
    issue_ready = 1'b1;
    pe_retire = 1'b0;
    start_job(16'd10, 16'd3);
    for (int c = 0; c < 60; c++) begin
      if (out_valid === 1'b1) n_out++;
      pe_retire = hs_prev;
      in_valid = 1'b0;
      issue_ready = 1'b1;
      if (issue_valid === 1'b1) begin
        checks++;
        if (curr_pixel !== ep || curr_weight !== ew) begin
          failures++;
          $display("FAIL stall_order got=(%0d,%0d) exp=(%0d,%0d)",
                   curr_pixel, curr_weight, ep, ew);
        end
        if (ep == 16'd1 && ew == 16'd0 && stall_left > 0) begin
          issue_ready = 1'b0;
          if (stall_left == 5) begin
            in_valid = 1'b1;
            fv = 16'd0;
            wv = 16'd0;
          end
          stall_left--;
        end else begin
          n_iss++;
          if (ep == 16'd2) begin
            ep = '0;
            ew = ew + 16'd1;
          end else begin
            ep = ep + 16'd1;
          end
        end
      end
      hs_prev = issue_valid && issue_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    pe_retire = 1'b0;
    issue_ready = 1'b1;
    checks++;
    if (n_iss != 9 || n_out != 1) begin
      failures++;
      $display("FAIL stall_total got=iss%0d,out%0d exp=9,1", n_iss, n_out);
    end
`ifdef SCHED_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd5) begin
      failures++;
      $display("FAIL stall_cnt got=%0d exp=5", stall_cycles);
    end
`endif
  endtask

  task automatic test_abort();
    issue_ready = 1'b1;
    pe_retire = 1'b0;
    start_job(16'd32, 16'd2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || issue_valid !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_state got=%0b%0b%0b exp=000",
               busy, issue_valid, out_valid);
    end
    pe_retire = 1'b1;
    repeat (2) @(negedge clk);
    pe_retire = 1'b0;
    start_job(16'd4, 16'd1);
    checks++;
    if (issue_valid !== 1'b1 || curr_pixel !== 16'd0 ||
        curr_weight !== 16'd0 || lane_mask !== 4'b1111) begin
      failures++;
      $display("FAIL abort_issue got=v%0b,(%0d,%0d,%b) exp=v1,(0,0,1111)",
               issue_valid, curr_pixel, curr_weight, lane_mask);
    end
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_single got=valid%0b,busy%0b exp=0,1",
               issue_valid, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_wait got=%0b exp=0", out_valid);
    end
    pe_retire = 1'b1;
    @(negedge clk);
    pe_retire = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_done got=%0b exp=1", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sweep(16'd10, 16'd3, 9);
    test_sweep(16'd3, 16'd2, 2);
    test_zero();
    test_drain();
    test_overlap();
    test_stall();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
